console_in_responder: RTL
=========================

// Module: console_in_responder
// PURPOSE
//   Device end of the CONSOLE_IN valid/ack byte interface. The host (UART bridge or bench)
//   presents a byte with CONSOLE_IN_valid; this block captures it into a FIFO and pulses
//   CONSOLE_IN_ack. It sits between the console pins and the processor's memory-mapped
//   input register: the CPU polls EMPTY and pops bytes with RD_EN.
// PARAMETERS
//   DEPTH   16  FIFO entries; power of two, >= 2
//   DATA_W  8   byte width
// PORTS
//   CLK               in   1                 system clock; all logic on rising edge
//   RESET             in   1                 synchronous, active-low reset
//   CONSOLE_IN        in   DATA_W            byte from host; sampled only when accepted
//   CONSOLE_IN_valid  in   1                 host has a byte; host holds it until after ack falls
//   CONSOLE_IN_ack    out  1                 one-cycle pulse: byte accepted
//   RD_EN             in   1                 CPU pop strobe (one pop per high cycle)
//   RD_DATA           out  DATA_W            FIFO head, first-word-fall-through
//   EMPTY             out  1                 FIFO holds no bytes
//   FULL              out  1                 FIFO holds DEPTH bytes
//   COUNT             out  $clog2(DEPTH)+1   bytes held
//   ECHO_DATA         out  DATA_W            echo byte (CONSOLE_IN_ECHO_EN only)
//   ECHO_valid        out  1                 echo byte pending
//   ECHO_ready        in   1                 echo sink accepts byte when high with ECHO_valid
// BEHAVIOUR
//   Reset (RESET==0 at an edge): CONSOLE_IN_ack=0, EMPTY=1, FULL=0, COUNT=0, RD_DATA=0,
//     ECHO_valid=0. Pointers cleared. The FSM enters WAIT_REL.
//   FSM states: IDLE, ACK, WAIT_REL.
//     IDLE: if CONSOLE_IN_valid && !FULL (&& !ECHO_valid with echo), write CONSOLE_IN to the
//       FIFO and go to ACK. Otherwise stay in IDLE.
//     ACK: CONSOLE_IN_ack=1 for this single cycle, then go to WAIT_REL.
//     WAIT_REL: if CONSOLE_IN_valid==0, go to IDLE. A byte is never captured twice.
//   Latency: valid sampled high at edge n -> byte written at edge n. From n+1: EMPTY=0,
//     COUNT is incremented, and ack is high for exactly one cycle.
//   FIFO full: no capture and no ack. valid stays pending, and the byte is accepted on the
//     first IDLE cycle after a pop frees a slot.
//   Pop: RD_EN && !EMPTY advances the head at the edge. RD_EN on EMPTY is ignored: no state
//     change, RD_DATA unchanged.
//   Simultaneous capture and pop: both take effect and COUNT is unchanged. A pop while FULL
//     makes the slot available to a capture from the next edge.
//   Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. FULL = (COUNT==DEPTH).
//   Reset mid-transfer: the FIFO is flushed and ack drops. A valid held through reset is
//     not re-captured (WAIT_REL).
// CONFIGURATION
//   CONSOLE_IN_ECHO_EN defined:
//     - Each captured byte is also loaded into ECHO_DATA, and ECHO_valid=1 from the next cycle.
//     - ECHO_valid stays high until ECHO_valid && ECHO_ready at an edge.
//     - No new capture while ECHO_valid=1.
//   CONSOLE_IN_ECHO_EN undefined: ECHO_DATA=0 and ECHO_valid=0 constant, ECHO_ready ignored,
//     and capture is gated only by FULL.
// TESTING
//   1 Reset, then valid=1 with 0x49 -> ack=1 for one cycle; EMPTY=0, COUNT=1, RD_DATA=0x49.
//     Hold valid 20 cycles -> no second ack, COUNT stays 1.
//   2 Send "1"," ","2","A" (valid dropped after each ack) -> COUNT=4. Four RD_EN pops give
//     0x31,0x20,0x32,0x41, then EMPTY=1. A fifth pop leaves all outputs unchanged.
//   3 Fill 16 bytes -> FULL=1. The 17th valid gets no ack. One pop -> the 17th byte is
//     acked, COUNT=16, and the bytes read back in order across the pointer wrap.
//   4 RD_EN on the same edge as a capture at COUNT=3 -> COUNT stays 3 and the head advances.
//   5 Assert RESET=0 during ACK with valid held -> ack=0, EMPTY=1 after reset. Drop valid,
//     then send 0x42 -> single ack, RD_DATA=0x42.
//   6 (ECHO_EN) ECHO_ready=0, send 0x41 -> ECHO_valid=1, ECHO_DATA=0x41, and a second byte
//     is not acked. ECHO_ready=1 -> echo clears and the second byte is acked.

Source files
------------

// File: rtl/console_in_responder.sv
// Device end of the CONSOLE_IN valid/ack byte port, buffered in a FWFT FIFO for CPU polling.
// Latency: byte written on the edge valid is sampled in IDLE; ack/EMPTY/COUNT update the next cycle.
// Backpressure: no capture/ack while FULL (or echo pending with CONSOLE_IN_ECHO_EN); host holds valid.
module console_in_responder #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        CONSOLE_IN,
    input  logic                     CONSOLE_IN_valid,
    output logic                     CONSOLE_IN_ack,
    input  logic                     RD_EN,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [DATA_W-1:0]        ECHO_DATA,
    output logic                     ECHO_valid,
    input  logic                     ECHO_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_REL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              capture;
    logic              ack_nxt;
    logic              echo_block;
    logic              do_pop;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    assign EMPTY  = (count == '0);
    assign FULL   = (count == FULL_CNT);
    assign COUNT  = count;
    assign do_pop = RD_EN && !EMPTY;

    // Storage is not reset; the head is masked to zero whenever nothing is held.
    assign RD_DATA = EMPTY ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (capture) begin
            mem[wr_ptr] <= CONSOLE_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional echo path
    // ------------------------------------------------------------------
`ifdef CONSOLE_IN_ECHO_EN
    logic [DATA_W-1:0] echo_dat;
    logic              echo_vld;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            echo_dat <= '0;
            echo_vld <= 1'b0;
        end else if (capture) begin
            echo_dat <= CONSOLE_IN;
            echo_vld <= 1'b1;
        end else if (echo_vld && ECHO_ready) begin
            echo_vld <= 1'b0;
        end
    end

    assign ECHO_DATA  = echo_dat;
    assign ECHO_valid = echo_vld;
    assign echo_block = echo_vld;
`else
    logic unused_echo_ready;

    assign unused_echo_ready = ECHO_ready;
    assign ECHO_DATA         = '0;
    assign ECHO_valid        = 1'b0;
    assign echo_block        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    // Reset lands in WAIT_REL so a valid held across reset is not taken again.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= WAIT_REL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (CONSOLE_IN_valid && !FULL && !echo_block) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                ack_nxt   = 1'b1;
                state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!CONSOLE_IN_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = WAIT_REL;
            end
        endcase
    end

    assign CONSOLE_IN_ack = ack_nxt;

endmodule
